// File: rtl/tsm_rnd_source.sv
// Seeded masking-randomness source: 64-bit Fibonacci LFSR (x^64+x^63+x^61+x^60+1),
// advanced 19 steps per enabled cycle, loaded via a 16-bit serial seed port.
module tsm_rnd_source #(
    parameter int WARMUP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed_word,
    input  logic        seed_valid,
    input  logic        en,
    output logic [18:0] PRNG,
    output logic        rnd_valid
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WARM,
        RUN
    } state_t;

    localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

    state_t      state;
    logic [63:0] s_p0;
    logic [1:0]  word_cnt;
    logic [7:0]  warm_cnt;
    logic [63:0] s_shift;

    // Nineteen LFSR steps unrolled into one combinational advance.
    function automatic logic [63:0] advance(input logic [63:0] s_in);
        logic [63:0] s_tmp;
        s_tmp = s_in;
        for (int i = 0; i < 19; i++) begin
            s_tmp = {s_tmp[62:0], s_tmp[63] ^ s_tmp[62] ^ s_tmp[60] ^ s_tmp[59]};
        end
        return s_tmp;
    endfunction

    assign s_shift = {s_p0[47:0], seed_word};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s_p0      <= '0;
            word_cnt  <= '0;
            warm_cnt  <= '0;
            rnd_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (seed_valid) begin
                        s_p0     <= s_shift;
                        word_cnt <= 2'd1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (seed_valid) begin
                        if (word_cnt == 2'd3) begin
                            // An all-zero state would lock the LFSR; substitute 1.
                            s_p0     <= (s_shift == 64'h0) ? 64'h1 : s_shift;
                            word_cnt <= 2'd0;
                            warm_cnt <= 8'd0;
                            state    <= WARM;
                        end else begin
                            s_p0     <= s_shift;
                            word_cnt <= word_cnt + 2'd1;
                        end
                    end
                end
                WARM: begin
                    if (seed_valid) begin
                        s_p0     <= s_shift;
                        word_cnt <= 2'd1;
                        warm_cnt <= 8'd0;
                        state    <= LOAD;
                    end else begin
                        s_p0 <= advance(s_p0);
                        if (warm_cnt == WARM_LAST) begin
                            warm_cnt  <= 8'd0;
                            rnd_valid <= 1'b1;
                            state     <= RUN;
                        end else begin
                            warm_cnt <= warm_cnt + 8'd1;
                        end
                    end
                end
                RUN: begin
                    // A new seed takes priority over consumption.
                    if (seed_valid) begin
                        s_p0      <= s_shift;
                        word_cnt  <= 2'd1;
                        rnd_valid <= 1'b0;
                        state     <= LOAD;
                    end else if (en) begin
                        s_p0 <= advance(s_p0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign PRNG = rnd_valid ? s_p0[18:0] : 19'h0;

endmodule

// File: tb/tb_tsm_rnd_source.sv
// Directed bench for tsm_rnd_source: reset, seeding, warm-up timing, zero-seed guard,
// stall/advance behaviour, reseed priority and mid-operation reset.
module tb_tsm_rnd_source;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] seed_word;
    logic        seed_valid;
    logic        en;
    logic [18:0] PRNG;
    logic        rnd_valid;
    logic [18:0] prng8;
    logic        vld8;

    int vecs = 0;
    int errs = 0;

    tsm_rnd_source #(.WARMUP(1)) dut (
        .clk(clk), .rst(rst), .seed_word(seed_word), .seed_valid(seed_valid),
        .en(en), .PRNG(PRNG), .rnd_valid(rnd_valid)
    );

    tsm_rnd_source #(.WARMUP(8)) dut8 (
        .clk(clk), .rst(rst), .seed_word(seed_word), .seed_valid(seed_valid),
        .en(en), .PRNG(prng8), .rnd_valid(vld8)
    );

    always #5 clk = ~clk;

    // Reference: one advance = 19 single steps of the stated polynomial.
    function automatic logic [63:0] model_adv(input logic [63:0] s);
        logic [63:0] r;
        logic        fb;
        r = s;
        for (int i = 0; i < 19; i++) begin
            fb = r[63] ^ r[62] ^ r[60] ^ r[59];
            r  = (r << 1) | {63'h0, fb};
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        vecs++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic load4(input logic [63:0] seed);
        for (int i = 0; i < 4; i++) begin
            seed_valid = 1'b1;
            seed_word  = seed[63-16*i -: 16];
            tick();
        end
        seed_valid = 1'b0;
        seed_word  = 16'h0;
    endtask

    initial begin
        logic [63:0] m;
        logic [63:0] rs;
        logic [63:0] ns;

        rst = 1'b1; seed_word = 16'h0; seed_valid = 1'b0; en = 1'b0;

        // Reset held for 20 cycles, then idle
        for (int i = 0; i < 20; i++) begin
            tick();
            check("rst_vld", {63'h0, rnd_valid}, 64'h0);
            check("rst_prng", {45'h0, PRNG}, 64'h0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_vld", {63'h0, rnd_valid}, 64'h0);
            check("idle_s", dut.s_p0, 64'h0);
        end

        // Seed 8000_0000_0000_0000, WARMUP=1 and WARMUP=8
        load4(64'h8000_0000_0000_0000);
        check("warm_vld", {63'h0, rnd_valid}, 64'h0);
        check("warm_prng", {45'h0, PRNG}, 64'h0);
        tick();
        check("w1_vld", {63'h0, rnd_valid}, 64'h1);
        check("w1_prng", {45'h0, PRNG}, 64'h40000);
        check("w8_vld_early", {63'h0, vld8}, 64'h0);
        en = 1'b1;
        tick();
        en = 1'b0;
        check("w1_adv_prng", {45'h0, PRNG}, 64'h0);
        check("w1_adv_s", dut.s_p0, 64'h1 << 37);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("w8_vld_wait", {63'h0, vld8}, 64'h0);
        end
        tick();
        m = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 8; i++) m = model_adv(m);
        check("w8_vld", {63'h0, vld8}, 64'h1);
        check("w8_prng", {45'h0, prng8}, {45'h0, m[18:0]});

        // All-zero seed is replaced by 1, then a long enabled run
        load4(64'h0);
        check("zero_s", dut.s_p0, 64'h1);
        check("zero_vld", {63'h0, rnd_valid}, 64'h0);
        tick();
        m = model_adv(64'h1);
        check("zero_first_vld", {63'h0, rnd_valid}, 64'h1);
        check("zero_first_prng", {45'h0, PRNG}, 64'h0);
        check("zero_first_s", dut.s_p0, m);
        en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            m = model_adv(m);
            check("zero_run", {45'h0, PRNG}, {45'h0, m[18:0]});
        end
        en = 1'b0;

        // Random seed, random enable
        rs = {$urandom, $urandom};
        load4(rs);
        tick();
        m = model_adv((rs == 64'h0) ? 64'h1 : rs);
        check("rnd_first_vld", {63'h0, rnd_valid}, 64'h1);
        check("rnd_first_prng", {45'h0, PRNG}, {45'h0, m[18:0]});
        for (int i = 0; i < 500; i++) begin
            en = 1'($urandom_range(0, 1));
            tick();
            if (en) m = model_adv(m);
            check("rnd_en_run", {45'h0, PRNG}, {45'h0, m[18:0]});
        end

        // Reseed from RUN with en high on the same cycle: seed wins
        ns = {$urandom, $urandom} | 64'h1;
        seed_valid = 1'b1;
        seed_word  = ns[63:48];
        en         = 1'b1;
        tick();
        seed_valid = 1'b0;
        en         = 1'b0;
        check("reseed_vld", {63'h0, rnd_valid}, 64'h0);
        check("reseed_prng", {45'h0, PRNG}, 64'h0);
        check("reseed_noadv", dut.s_p0, {m[47:0], ns[63:48]});
        for (int i = 1; i < 4; i++) begin
            seed_valid = 1'b1;
            seed_word  = ns[63-16*i -: 16];
            tick();
            check("reseed_load_vld", {63'h0, rnd_valid}, 64'h0);
        end
        seed_valid = 1'b0;
        tick();
        m = model_adv(ns);
        check("reseed_vld_up", {63'h0, rnd_valid}, 64'h1);
        check("reseed_prng_up", {45'h0, PRNG}, {45'h0, m[18:0]});
        en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            m = model_adv(m);
            check("reseed_run", {45'h0, PRNG}, {45'h0, m[18:0]});
        end
        en = 1'b0;

        // Reset in LOAD after two words
        for (int i = 0; i < 2; i++) begin
            seed_valid = 1'b1;
            seed_word  = 16'h1234 + 16'(i);
            tick();
        end
        seed_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_load_vld", {63'h0, rnd_valid}, 64'h0);
        check("rst_load_prng", {45'h0, PRNG}, 64'h0);
        check("rst_load_s", dut.s_p0, 64'h0);
        tick();
        check("rst_load_idle", {63'h0, rnd_valid}, 64'h0);
        load4(64'h8000_0000_0000_0000);
        check("reload_s", dut.s_p0, 64'h8000_0000_0000_0000);

        // Reset mid-warm-up, then a clean load
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_warm_vld", {63'h0, rnd_valid}, 64'h0);
        check("rst_warm_prng", {45'h0, PRNG}, 64'h0);
        check("rst_warm_s", dut.s_p0, 64'h0);
        check("rst_warm_vld8", {63'h0, vld8}, 64'h0);
        tick();
        check("rst_warm_idle", {63'h0, rnd_valid}, 64'h0);
        load4(64'h8000_0000_0000_0000);
        tick();
        check("post_rst_vld", {63'h0, rnd_valid}, 64'h1);
        check("post_rst_prng", {45'h0, PRNG}, 64'h40000);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/tsm_rnd_source.md
# tsm_rnd_source

Seeded masking-randomness generator that feeds the 19-bit `PRNG` bus of the two-stage masked 4-bit inversion stage in the AES S-box datapath. A 64-bit Fibonacci LFSR advances 19 steps per enabled cycle. It is loaded through a 16-bit serial seed port and warmed up before any output is released. `rnd_valid` gates consumption; `PRNG` is forced to zero while the stream is not valid, so seed material never leaks.

## Interface
- `WARMUP`, 8, number of discarded advance cycles after seeding; legal range 1..255

- `clk` input 1: rising-edge clock
- `rst` input 1: synchronous, active-high reset
- `seed_word` input 16: seed data word, most-significant word first
- `seed_valid` input 1: `seed_word` is sampled this cycle
- `en` input 1: consumer takes fresh randomness this cycle (RUN only)
- `PRNG` output 19: randomness to the masked inversion stage
- `rnd_valid` output 1: `PRNG` holds valid fresh randomness

## Operation
- State register `S[63:0]`.
- One LFSR step: `fb = S[63]^S[62]^S[60]^S[59]`, then `S = {S[62:0], fb}`. The polynomial is x^64+x^63+x^61+x^60+1.
- One advance applies 19 steps combinationally, unrolled in a single cycle.
- `PRNG = rnd_valid ? S[18:0] : 0`. This is combinational from registers, so there is no output glitch path from inputs.
- FSM states:
  - IDLE: reset state. No advance. Goes to LOAD on `seed_valid`.
  - LOAD: each `seed_valid` sets `S <= {S[47:0], seed_word}` and increments the 2-bit word counter. On the 4th word, go to WARMUP.
  - WARMUP: advance every cycle regardless of `en`. A counter counts to `WARMUP`, then go to RUN.
  - RUN: `rnd_valid=1`. Advance only when `en=1`; otherwise hold `S`.
- Word counting: the first word received from IDLE, WARMUP or RUN counts as word 0. That word is shifted in, the counter is set to 1, and the state goes to LOAD.
- Zero-seed guard: if the 4th word completes with the resulting `S==0`, load `S = 64'h1` instead.
- `seed_valid` low in LOAD: hold `S` and the counter. There is no timeout.
- Simultaneous `seed_valid` and `en` in RUN: seed wins. There is no advance, and `rnd_valid` falls the next cycle.
- Reset values: `S=0`, state IDLE, both counters 0, `rnd_valid=0`, `PRNG=0`.
- `rst` mid-operation: returns to reset values on the next edge, regardless of state.

## Timing
- A seed word presented at cycle k is registered at edge k+1.
- If the 4 words arrive at consecutive cycles k..k+3, WARMUP occupies cycles k+4 .. k+3+WARMUP.
- `rnd_valid` rises at cycle k+4+WARMUP with `PRNG` already showing the post-warm-up `S[18:0]`.
- In RUN, with `en=1` at cycle t, the new `PRNG` value appears at t+1. One 19-bit word is consumed per enabled cycle, with no bubbles.
- With `en=0`, `PRNG` is stable. The consumer must not reuse a word across enabled cycles.
- Reseed from RUN: `rnd_valid` is 0 from the cycle after the first `seed_valid` until WARMUP completes again.

## Test plan
- Reset with `seed_valid=0`, 20 cycles → `rnd_valid=0` and `PRNG=0` throughout. After `rst` is released, the block stays in IDLE.
- `WARMUP=1`, seed words 8000,0000,0000,0000 at cycles 0..3 → `rnd_valid` rises at cycle 5 with `PRNG=19'h40000`. `en=1` at cycle 5 → `PRNG=19'h00000` at cycle 6 (`S=1<<37`).
- All-zero seed, `WARMUP=1` → the internal `S` equals 1 after the load. `rnd_valid` rises after 1 warm-up cycle with `PRNG=19'h00000`, because `S=1<<19`. The bench compares against a bit-accurate software model for 10,000 enabled cycles.
- RUN with random `en` (50%) and a random seed → `PRNG` changes only the cycle after `en=1`. The sequence matches the model exactly, and stall cycles hold the value.
- Reseed from RUN with `seed_valid` and `en` both high → no advance that cycle. `rnd_valid=0` the next cycle, `PRNG=0`, and the stream after the new warm-up matches the model for the new seed.
- Assert `rst` in LOAD after 2 words and again mid-WARMUP → all outputs are 0 next cycle. A following full seed load behaves exactly as from power-up.
